// File: rtl/fetch_inst_queue.sv
// Fetch-to-decode instruction queue: a DEPTH-entry FIFO of {pc, inst}.
// The head is presented fall-through. Stall, flush and overflow reporting are included.
module fetch_inst_queue #(
  parameter int unsigned ADDR  = 32,
  parameter int unsigned INST  = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned SKID  = 1
) (
  input  logic                         clk,
  input  logic                         reset_,
  input  logic                         flush_,
  input  logic                         in_e_,
  input  logic [ADDR-1:0]              in_pc,
  input  logic [INST-1:0]              in_inst,
  output logic                         fetch_stall,
  input  logic                         dec_stall,
  output logic                         out_e_,
  output logic [ADDR-1:0]              out_pc,
  output logic [INST-1:0]              out_inst,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         ovf
);

  localparam int unsigned CNT   = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [ADDR-1:0] pc;
    logic [INST-1:0] inst;
  } entry_t;

  entry_t            mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic              full;
  logic              deq;
  logic              enq;
  logic              drop;

  // Handshake decode. When the queue is full, a write is accepted only if the head leaves in the same cycle.
  always_comb begin
    full = (count == CNT'(DEPTH));
    deq  = (count != '0) && !dec_stall;
    enq  = !in_e_ && (!full || deq);
    drop = !in_e_ && full && !deq;
  end

  assign out_e_      = (count == '0);
  assign out_pc      = mem[rd_ptr].pc;
  assign out_inst    = mem[rd_ptr].inst;
  assign fetch_stall = (count >= CNT'(DEPTH - SKID));

  // Pointer, occupancy and sticky overflow state. Flush has priority over traffic.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else if (!flush_) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
      if (enq && !deq)      count <= count + CNT'(1);
      else if (deq && !enq) count <= count - CNT'(1);
      if (drop) ovf <= 1'b1;
    end
  end

  // Entry storage has no reset; only slots that the pointers cover are ever read as valid.
  always_ff @(posedge clk) begin
    if (reset_ && flush_ && enq) begin
      mem[wr_ptr] <= '{pc: in_pc, inst: in_inst};
    end
  end

endmodule

// File: tb/tb_fetch_inst_queue.sv
// Directed, self-checking bench for fetch_inst_queue (DEPTH=4, SKID=1).
module tb_fetch_inst_queue;

  logic        clk = 1'b0;
  logic        reset_;
  logic        flush_;
  logic        in_e_;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic        fetch_stall;
  logic        dec_stall;
  logic        out_e_;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [2:0]  count;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  fetch_inst_queue #(.ADDR(32), .INST(32), .DEPTH(4), .SKID(1)) dut (
    .clk(clk), .reset_(reset_), .flush_(flush_), .in_e_(in_e_),
    .in_pc(in_pc), .in_inst(in_inst), .fetch_stall(fetch_stall),
    .dec_stall(dec_stall), .out_e_(out_e_), .out_pc(out_pc),
    .out_inst(out_inst), .count(count), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        fl;
    logic        ie;
    logic [31:0] pc;
    logic        ds;
    logic        e_oe;
    logic [31:0] e_pc;
    int          e_cnt;
    logic        e_fs;
    logic        e_ovf;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(string name, logic fl, logic ie, logic [31:0] pc, logic ds,
                              logic e_oe, logic [31:0] e_pc, int e_cnt, logic e_fs, logic e_ovf);
    vec_t v;
    v.name = name; v.fl = fl; v.ie = ie; v.pc = pc; v.ds = ds;
    v.e_oe = e_oe; v.e_pc = e_pc; v.e_cnt = e_cnt; v.e_fs = e_fs; v.e_ovf = e_ovf;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic fl, input logic ie, input logic [31:0] pc, input logic ds);
    flush_ = fl; in_e_ = ie; in_pc = pc; in_inst = ~pc; dec_stall = ds;
  endtask

  task automatic check_state(input string nm, input logic e_oe, input logic [31:0] e_pc,
                             input int e_cnt, input logic e_fs, input logic e_ovf);
    chk({nm, "_out_e"}, 32'(out_e_), 32'(e_oe));
    chk({nm, "_count"}, 32'(count), 32'(e_cnt));
    chk({nm, "_fstall"}, 32'(fetch_stall), 32'(e_fs));
    chk({nm, "_ovf"}, 32'(ovf), 32'(e_ovf));
    if (!e_oe) begin
      chk({nm, "_pc"}, out_pc, e_pc);
      chk({nm, "_inst"}, out_inst, ~e_pc);
    end
  endtask

  initial begin
    // Reset then idle
    for (int i = 0; i < 5; i++) add("idle", 1, 1, 32'h0, 0, 1, 32'h0, 0, 0, 0);
    // Fill and drain
    add("fill0", 1, 0, 32'h100, 1, 0, 32'h100, 1, 0, 0);
    add("fill1", 1, 0, 32'h104, 1, 0, 32'h100, 2, 0, 0);
    add("fill2", 1, 0, 32'h108, 1, 0, 32'h100, 3, 1, 0);
    add("fill3", 1, 0, 32'h10C, 1, 0, 32'h100, 4, 1, 0);
    add("drain0", 1, 1, 32'h0, 0, 0, 32'h104, 3, 1, 0);
    add("drain1", 1, 1, 32'h0, 0, 0, 32'h108, 2, 0, 0);
    add("drain2", 1, 1, 32'h0, 0, 0, 32'h10C, 1, 0, 0);
    add("drain3", 1, 1, 32'h0, 0, 1, 32'h0, 0, 0, 0);
    // Full with simultaneous read and write
    add("rw_f0", 1, 0, 32'h110, 1, 0, 32'h110, 1, 0, 0);
    add("rw_f1", 1, 0, 32'h114, 1, 0, 32'h110, 2, 0, 0);
    add("rw_f2", 1, 0, 32'h118, 1, 0, 32'h110, 3, 1, 0);
    add("rw_f3", 1, 0, 32'h11C, 1, 0, 32'h110, 4, 1, 0);
    add("rw_both", 1, 0, 32'h200, 0, 0, 32'h114, 4, 1, 0);
    add("rw_d0", 1, 1, 32'h0, 0, 0, 32'h118, 3, 1, 0);
    add("rw_d1", 1, 1, 32'h0, 0, 0, 32'h11C, 2, 0, 0);
    add("rw_d2", 1, 1, 32'h0, 0, 0, 32'h200, 1, 0, 0);
    add("rw_d3", 1, 1, 32'h0, 0, 1, 32'h0, 0, 0, 0);
    // Overflow
    add("ov_f0", 1, 0, 32'h120, 1, 0, 32'h120, 1, 0, 0);
    add("ov_f1", 1, 0, 32'h124, 1, 0, 32'h120, 2, 0, 0);
    add("ov_f2", 1, 0, 32'h128, 1, 0, 32'h120, 3, 1, 0);
    add("ov_f3", 1, 0, 32'h12C, 1, 0, 32'h120, 4, 1, 0);
    add("ov_drop", 1, 0, 32'h300, 1, 0, 32'h120, 4, 1, 1);
    add("ov_d0", 1, 1, 32'h0, 0, 0, 32'h124, 3, 1, 1);
    add("ov_d1", 1, 1, 32'h0, 0, 0, 32'h128, 2, 0, 1);
    add("ov_d2", 1, 1, 32'h0, 0, 0, 32'h12C, 1, 0, 1);
    add("ov_d3", 1, 1, 32'h0, 0, 1, 32'h0, 0, 0, 1);
    add("ov_hold", 1, 1, 32'h0, 0, 1, 32'h0, 0, 0, 1);
    add("ov_flush", 0, 1, 32'h0, 0, 1, 32'h0, 0, 0, 0);
    // Empty with valid input: no bypass, head appears the cycle after the write
    add("nobyp", 1, 0, 32'h140, 0, 0, 32'h140, 1, 0, 0);
    add("nobyp_d", 1, 1, 32'h0, 0, 1, 32'h0, 0, 0, 0);
    // Flush mid-operation
    add("fl_f0", 1, 0, 32'h130, 1, 0, 32'h130, 1, 0, 0);
    add("fl_f1", 1, 0, 32'h134, 1, 0, 32'h130, 2, 0, 0);
    add("fl_f2", 1, 0, 32'h138, 1, 0, 32'h130, 3, 1, 0);
    add("fl_go", 0, 0, 32'h1FC, 0, 1, 32'h0, 0, 0, 0);
    add("fl_hold", 0, 0, 32'h1F8, 1, 1, 32'h0, 0, 0, 0);
    add("fl_new", 1, 0, 32'h400, 1, 0, 32'h400, 1, 0, 0);

    drive(1, 1, 32'h0, 0);
    reset_ = 1'b0;
    #12;
    check_state("rst", 1, 32'h0, 0, 0, 0);
    reset_ = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].fl, vecs[i].ie, vecs[i].pc, vecs[i].ds);
      @(posedge clk); #1;
      check_state(vecs[i].name, vecs[i].e_oe, vecs[i].e_pc, vecs[i].e_cnt, vecs[i].e_fs, vecs[i].e_ovf);
    end

    // Asynchronous reset while the queue holds an entry
    drive(1, 1, 32'h0, 1);
    #2 reset_ = 1'b0;
    #1 check_state("arst", 1, 32'h0, 0, 0, 0);
    @(negedge clk);
    reset_ = 1'b1;
    @(posedge clk); #1;

    // Wrap-around stream against a queue model, decode stalling every other cycle
    begin
      logic [31:0] sq[$];
      int sent = 0;
      int mcnt = 0;
      int cyc = 0;
      logic offer, mdeq, macc;
      while ((sent < 10 || mcnt > 0) && cyc < 200) begin
        offer = (sent < 10) && (mcnt < 3);
        drive(1, !offer, 32'h500 + 32'(sent * 4), cyc[0] == 1'b0);
        mdeq = (mcnt > 0) && !dec_stall;
        if (mdeq) begin
          chk("wrap_pc", out_pc, sq[0]);
          chk("wrap_inst", out_inst, ~sq[0]);
          void'(sq.pop_front());
        end
        macc = offer && (mcnt < 4 || mdeq);
        if (macc) begin
          sq.push_back(in_pc);
          sent++;
        end
        mcnt = mcnt + int'(macc) - int'(mdeq);
        @(posedge clk); #1;
        chk("wrap_count", 32'(count), 32'(mcnt));
        chk("wrap_out_e", 32'(out_e_), 32'(mcnt == 0));
        cyc++;
      end
      checks++;
      if (cyc >= 200) begin
        errors++;
        $display("FAIL wrap_timeout actual=%0d required=<200", cyc);
      end
      chk("wrap_sent", 32'(sent), 32'd10);
      chk("wrap_ovf", 32'(ovf), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
